pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that supersedes the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a valid/ready handshake, back-pressure, synchronous flush with bubble insertion, and an optional two-entry skid buffer. It sits between any two pipeline stages. Control fields are zeroed on flush so the downstream stage sees a harmless bubble.

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush bubbles and optional skid entry
// Ports: clk, rst (sync, active-high), flush (squash held entries);
//   in_valid/in_ready/in_data/in_ctrl from upstream, out_valid/out_ready/out_data/out_ctrl
//   to downstream, occupancy = number of held entries.
// Define PIPE_SKID_EN for a second (skid) entry so in_ready depends on registers only.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic              r_main_v, w_main_v;
  logic [DATA_W-1:0] r_main_d, w_main_d;
  logic [CTRL_W-1:0] r_main_c, w_main_c;
  logic              w_in_acc, w_out_acc;
  assign w_in_acc  = in_valid & in_ready;
  assign w_out_acc = r_main_v & out_ready;
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;
  assign out_ctrl  = r_main_c;
`ifdef PIPE_SKID_EN
  logic              r_skid_v, w_skid_v;
  logic [DATA_W-1:0] r_skid_d, w_skid_d;
  logic [CTRL_W-1:0] r_skid_c, w_skid_c;
  assign in_ready  = !r_skid_v & !rst;
  assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};
  // Skid only fills when main is held; a full skid blocks input, so TWO never sees an input accept.
  always_comb begin
    w_main_v = r_main_v;
    w_main_d = r_main_d;
    w_main_c = r_main_c;
    w_skid_v = r_skid_v;
    w_skid_d = r_skid_d;
    w_skid_c = r_skid_c;
    if (flush) begin
      w_main_v = 1'b0;
      w_main_c = '0;
      w_skid_v = 1'b0;
      w_skid_c = '0;
    end else if (r_skid_v) begin
      if (w_out_acc) begin
        w_main_d = r_skid_d;
        w_main_c = r_skid_c;
        w_skid_v = 1'b0;
      end
    end else if (w_in_acc && (!r_main_v || w_out_acc)) begin
      w_main_v = 1'b1;
      w_main_d = in_data;
      w_main_c = in_ctrl;
    end else if (w_in_acc) begin
      w_skid_v = 1'b1;
      w_skid_d = in_data;
      w_skid_c = in_ctrl;
    end else if (w_out_acc) begin
      w_main_v = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_main_d <= '0;
      r_main_c <= '0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
      r_skid_c <= '0;
    end else begin
      r_main_v <= w_main_v;
      r_main_d <= w_main_d;
      r_main_c <= w_main_c;
      r_skid_v <= w_skid_v;
      r_skid_d <= w_skid_d;
      r_skid_c <= w_skid_c;
    end
  end
`else
  // Single entry: accepting while the held entry leaves keeps full throughput.
  assign in_ready  = (!r_main_v | out_ready) & !rst;
  assign occupancy = {1'b0, r_main_v};
  always_comb begin
    w_main_v = r_main_v;
    w_main_d = r_main_d;
    w_main_c = r_main_c;
    if (flush) begin
      w_main_v = 1'b0;
      w_main_c = '0;
    end else if (w_in_acc) begin
      w_main_v = 1'b1;
      w_main_d = in_data;
      w_main_c = in_ctrl;
    end else if (w_out_acc) begin
      w_main_v = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_main_d <= '0;
      r_main_c <= '0;
    end else begin
      r_main_v <= w_main_v;
      r_main_d <= w_main_d;
      r_main_c <= w_main_c;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven check of pipe_stage_reg in either build
module tb_pipe_stage_reg;
  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] id;
    logic [4:0]  ic;
    logic        ordy, e_ir, e_ov;
    logic [31:0] e_od;
    logic [4:0]  e_oc;
    logic [1:0]  e_occ;
    logic        md, mc;
  } vec_t;
`ifdef PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif
  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_ctrl, out_ctrl;
  logic [1:0]  occupancy;
  vec_t        vq[$];
  int          n_vec = 0;
  int          n_bad = 0;
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic add(input logic r, f, iv, input logic [31:0] id, input logic ordy, e_ir, e_ov,
                     input logic [31:0] e_od, input logic [1:0] e_occ, input logic md, mc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ic = id[4:0] ^ 5'h15;
    v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    v.e_oc = e_ov ? (e_od[4:0] ^ 5'h15) : 5'h0;
    v.e_occ = e_occ; v.md = md; v.mc = mc;
    vq.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; flush = v.flush; in_valid = v.iv; in_data = v.id; in_ctrl = v.ic; out_ready = v.ordy;
    #1;
    chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.e_ir));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.e_ov));
    chk($sformatf("v%0d occupancy", idx), 32'(occupancy), 32'(v.e_occ));
    if (v.md) chk($sformatf("v%0d out_data", idx), out_data, v.e_od);
    if (v.mc) chk($sformatf("v%0d out_ctrl", idx), 32'(out_ctrl), 32'(v.e_oc));
    n_vec++;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) add(1, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 8; i++) add(0, 0, 1, i, 1, 1, 1, i, 1, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
`ifdef PIPE_SKID_EN
    add(0, 0, 1, 'h10, 1, 1, 1, 'h10, 1, 1, 1);
    add(0, 0, 1, 'h11, 0, 1, 1, 'h10, 2, 1, 1);
    add(0, 0, 1, 'h12, 0, 0, 1, 'h10, 2, 1, 1);
    add(0, 0, 1, 'h12, 1, 0, 1, 'h11, 1, 1, 1);
    add(0, 0, 1, 'h12, 1, 1, 1, 'h12, 1, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h30, 0, 1, 1, 'h30, 1, 1, 1);
    add(0, 0, 1, 'h31, 0, 1, 1, 'h30, 2, 1, 1);
    add(0, 1, 1, 'h99, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
`else
    add(0, 0, 1, 'h10, 1, 1, 1, 'h10, 1, 1, 1);
    add(0, 0, 1, 'h11, 0, 0, 1, 'h10, 1, 1, 1);
    add(0, 0, 1, 'h11, 0, 0, 1, 'h10, 1, 1, 1);
    add(0, 0, 1, 'h11, 1, 1, 1, 'h11, 1, 1, 1);
    add(0, 0, 1, 'h12, 1, 1, 1, 'h12, 1, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h30, 0, 1, 1, 'h30, 1, 1, 1);
    add(0, 1, 1, 'h99, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
`endif
    add(0, 0, 1, 'h40, 1, 1, 1, 'h40, 1, 1, 1);
    add(0, 1, 1, 'h99, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 'h55, 1, 1, 1, 'h55, 1, 1, 1);
`ifdef PIPE_SKID_EN
    for (int i = 0; i < 10; i++) add(0, 0, i % 2 == 0, 'hA0 + i, 0, i == 0, 1, 'h55, 2, 1, 1);
    add(0, 0, 0, 0, 1, 0, 1, 'hA0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
`else
    for (int i = 0; i < 10; i++) add(0, 0, i % 2 == 0, 'hA0 + i, 0, 0, 1, 'h55, 1, 1, 1);
    add(0, 0, 1, 'h56, 1, 1, 1, 'h56, 1, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
`endif
    add(0, 0, 1, 'h66, 0, 1, 1, 'h66, 1, 1, 1);
    add(1, 0, 1, 'h67, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    foreach (vq[i]) apply(vq[i], i);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h42; in_ctrl = 5'h0C; out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("ready_low_path", 32'(in_ready), 32'(SKID));
    out_ready = 1'b1;
    #1;
    chk("ready_high_path", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    #1;
    chk("ready_low_again", 32'(in_ready), 32'(SKID));
    @(posedge clk);
    #1;
    chk("held_data", out_data, 32'h42);
    chk("held_ctrl", 32'(out_ctrl), 32'h0C);
    n_vec++;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_occ", 32'(occupancy), 32'd0);
    n_vec++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
